// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, mid-bit sampling driven by an external baud tick,
// optional parity and stop check, one-entry valid/ready holding register for the consumer.
module uart_rx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 rxd,
    input  logic                 bit_tick,
    output logic                 bps_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic                 rxd_m, rxd_s, rxd_h;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic                 par_bit, par_bit_nxt;
    logic                 fall, stop_tick, par_ok, good;

    // Metastability pair plus one history stage for edge detection
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_h <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_h <= rxd_s;
        end
    end

    assign fall = rxd_h & ~rxd_s;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            par_bit <= par_bit_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        par_bit_nxt = par_bit;
        case (state)
            IDLE: if (fall) state_nxt = START;
            START: if (bit_tick) begin
                if (!rxd_s) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: if (bit_tick) begin
                shreg_nxt   = {rxd_s, shreg[DATA_BITS-1:1]};
                bit_cnt_nxt = bit_cnt + 4'd1;
                if (bit_cnt == LAST_BIT) state_nxt = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (bit_tick) begin
                par_bit_nxt = rxd_s;
                state_nxt   = STOP;
            end
            STOP: if (bit_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Baud generator runs for the whole frame, START through the stop sample
    assign bps_en    = (state != IDLE);
    assign stop_tick = (state == STOP) & bit_tick;
    assign par_ok    = (PARITY == 0) || ((^shreg ^ par_bit) == (PARITY == 1));
    assign good      = stop_tick & rxd_s & par_ok;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= stop_tick & ~rxd_s;
            parity_err <= stop_tick & rxd_s & ~par_ok;
            overrun    <= good & rx_valid & ~rx_ready;
            // A same-cycle accept frees the slot for the incoming byte
            if (good && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: two instances (no parity / even parity) fed by a 16-clk baud model,
// directed cases plus random frames scored against a frame-level outcome model.
module tb_uart_rx_frame;

    localparam int BPS = 16;
    localparam int DB  = 8;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic [1:0] rxd = 2'b11;
    logic [1:0] rx_ready = 2'b11;
    logic [1:0] bit_tick, bps_en, rx_valid, frame_err, parity_err, overrun;
    logic [DB-1:0] rx_data [2];

    always #5 clk = ~clk;

    uart_rx_frame #(.DATA_BITS(DB), .PARITY(0)) u0 (
        .clk(clk), .RSTn(RSTn), .rxd(rxd[0]), .bit_tick(bit_tick[0]), .bps_en(bps_en[0]),
        .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0]));

    uart_rx_frame #(.DATA_BITS(DB), .PARITY(2)) u1 (
        .clk(clk), .RSTn(RSTn), .rxd(rxd[1]), .bit_tick(bit_tick[1]), .bps_en(bps_en[1]),
        .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1]));

    // Baud generator model: mid-bit pulse half a bit period after enable
    for (genvar g = 0; g < 2; g++) begin : bg
        int c;
        always @(posedge clk or negedge RSTn) begin
            if (!RSTn)          c <= 0;
            else if (!bps_en[g]) c <= 0;
            else                c <= (c == BPS - 1) ? 0 : c + 1;
        end
        assign bit_tick[g] = bps_en[g] && (c == BPS / 2 - 1);
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Observed activity
    int n_fe[2], n_pe[2], n_ov[2], n_bps[2], n_vcyc[2];
    logic [7:0] got_q0[$], got_q1[$];
    logic [1:0] bps_d = 2'b00, pv = 2'b00, pa = 2'b00;
    logic [7:0] pd [2];
    logic prst = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (RSTn && prst) begin
                if (frame_err[i])  n_fe[i]++;
                if (parity_err[i]) n_pe[i]++;
                if (overrun[i])    n_ov[i]++;
                if (rx_valid[i])   n_vcyc[i]++;
                if (bps_en[i] && !bps_d[i]) n_bps[i]++;
                if (rx_valid[i] && rx_ready[i]) begin
                    if (i == 0) got_q0.push_back(rx_data[i]);
                    else        got_q1.push_back(rx_data[i]);
                end
                if (pv[i] && !pa[i]) chk("hold_stable", rx_data[i], pd[i]);
            end
            bps_d[i] = bps_en[i];
            pv[i]    = rx_valid[i];
            pa[i]    = rx_valid[i] & rx_ready[i];
            pd[i]    = rx_data[i];
        end
        prst = RSTn;
    end

    // Reference model: frame outcome from the bits sent, plus holding-slot occupancy
    int e_fe[2], e_pe[2], e_ov[2];
    logic [7:0] exp_q0[$], exp_q1[$];
    bit hold_full[2];
    logic [7:0] hold_d[2];

    task automatic push_exp(input int i, input logic [7:0] d);
        if (i == 0) exp_q0.push_back(d);
        else        exp_q1.push_back(d);
    endtask

    task automatic model_frame(input int i, input logic [7:0] d, input logic pb, input logic sb);
        int ones;
        ones = $countones(d) + int'(pb);
        if (!sb)                                e_fe[i]++;
        else if (i == 1 && (ones % 2) != 0)     e_pe[i]++;
        else if (hold_full[i] && !rx_ready[i])  e_ov[i]++;
        else if (rx_ready[i])                   push_exp(i, d);
        else begin
            hold_full[i] = 1'b1;
            hold_d[i]    = d;
        end
    endtask

    task automatic set_ready(input int i, input logic v);
        rx_ready[i] = v;
        if (v && hold_full[i]) begin
            push_exp(i, hold_d[i]);
            hold_full[i] = 1'b0;
        end
    endtask

    task automatic compare_all(input int i);
        chk("frame_err_cnt", n_fe[i], e_fe[i]);
        chk("parity_err_cnt", n_pe[i], e_pe[i]);
        chk("overrun_cnt", n_ov[i], e_ov[i]);
        if (i == 0) begin
            chk("q0_len", got_q0.size(), exp_q0.size());
            while (got_q0.size() > 0 && exp_q0.size() > 0)
                chk("q0_byte", got_q0.pop_front(), exp_q0.pop_front());
            got_q0.delete(); exp_q0.delete();
        end else begin
            chk("q1_len", got_q1.size(), exp_q1.size());
            while (got_q1.size() > 0 && exp_q1.size() > 0)
                chk("q1_byte", got_q1.pop_front(), exp_q1.pop_front());
            got_q1.delete(); exp_q1.delete();
        end
    endtask

    task automatic hold_bit(input int i, input logic b);
        rxd[i] = b;
        repeat (BPS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input logic pb, input logic sb,
                              input bit keep_low);
        @(posedge clk); #1;
        hold_bit(i, 1'b0);
        for (int b = 0; b < DB; b++) hold_bit(i, d[b]);
        if (i == 1) hold_bit(i, pb);
        hold_bit(i, sb);
        if (!keep_low) rxd[i] = 1'b1;
        repeat (BPS) @(posedge clk);
        #1;
        model_frame(i, d, pb, sb);
    endtask

    function automatic logic even_pb(input logic [7:0] d);
        return ($countones(d) % 2) != 0;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, v0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_bps_en", bps_en[i], 1'b0);
            chk("rst_valid", rx_valid[i], 1'b0);
            chk("rst_data", rx_data[i], 8'h00);
            chk("rst_errs", {frame_err[i], parity_err[i], overrun[i]}, 3'b000);
        end
        RSTn = 1'b1;
        repeat (4) @(posedge clk);

        // Good byte 8N1
        v0 = n_vcyc[0];
        send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
        compare_all(0);
        chk("a5_valid_cycles", n_vcyc[0] - v0, 1);
        chk("a5_bps_off", bps_en[0], 1'b0);

        // Glitch shorter than half a bit
        b0 = n_bps[0]; v0 = n_vcyc[0];
        @(posedge clk); #1;
        rxd[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd[0] = 1'b1;
        repeat (3 * BPS) @(posedge clk);
        #1;
        chk("glitch_bps_rise", n_bps[0] - b0, 1);
        chk("glitch_bps_off", bps_en[0], 1'b0);
        chk("glitch_no_valid", n_vcyc[0] - v0, 0);
        compare_all(0);

        // Frame error, then line stuck low for two frames
        b0 = n_bps[0];
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1);
        repeat (2 * 10 * BPS) @(posedge clk);
        #1;
        chk("fe_bps_rise", n_bps[0] - b0, 1);
        chk("fe_bps_off", bps_en[0], 1'b0);
        compare_all(0);
        rxd[0] = 1'b1;
        repeat (BPS) @(posedge clk);
        #1;
        chk("fe_no_restart", n_bps[0] - b0, 1);

        // Even parity
        send_frame(1, 8'h07, 1'b1, 1'b1, 0);
        chk("par_good_data", rx_data[1], 8'h07);
        send_frame(1, 8'h07, 1'b0, 1'b1, 0);
        compare_all(1);

        // Overrun with consumer stalled
        set_ready(0, 1'b0);
        send_frame(0, 8'h11, 1'b0, 1'b1, 0);
        send_frame(0, 8'h22, 1'b0, 1'b1, 0);
        chk("ovr_valid", rx_valid[0], 1'b1);
        chk("ovr_data", rx_data[0], 8'h11);
        @(posedge clk); #1;
        set_ready(0, 1'b1);
        @(posedge clk); #1;
        rx_ready[0] = 1'b0;
        chk("ovr_drain_valid", rx_valid[0], 1'b0);
        set_ready(0, 1'b1);
        compare_all(0);

        // Reset during bit 3 of 8'hFF
        @(posedge clk); #1;
        hold_bit(0, 1'b0);
        for (int b = 0; b < 3; b++) hold_bit(0, 1'b1);
        repeat (BPS / 2) @(posedge clk);
        #1 RSTn = 1'b0;
        #1;
        chk("midrst_bps_en", bps_en[0], 1'b0);
        chk("midrst_valid", rx_valid[0], 1'b0);
        chk("midrst_data", rx_data[0], 8'h00);
        chk("midrst_errs", {frame_err[0], parity_err[0], overrun[0]}, 3'b000);
        repeat (3) @(posedge clk);
        #1 RSTn = 1'b1;
        repeat (2 * BPS) @(posedge clk);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 0);
        compare_all(0);

        // Random frames: data, stop bit, parity bit and consumer readiness all varied
        for (int n = 0; n < 24; n++) begin
            int i;
            logic [7:0] d;
            logic sb, pb;
            i  = int'($urandom % 2);
            d  = 8'($urandom);
            sb = ($urandom % 6) != 0;
            pb = even_pb(d) ^ (($urandom % 4) == 0);
            set_ready(i, ($urandom % 3) != 0);
            send_frame(i, d, pb, sb, 0);
            compare_all(i);
        end
        set_ready(0, 1'b1);
        set_ready(1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        compare_all(0);
        compare_all(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
